// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with iterative unsigned multiply/divide.
// Single-cycle ops finish in one clock. MUL/MULHU/DIVU/REMU use one shared
// {hi,lo} shift register for WIDTH steps and then one more cycle to register
// the result.
module alu_seq #(
  parameter int WIDTH         = 32,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_decode,
  input  logic [WIDTH-1:0] rda,
  input  logic [WIDTH-1:0] rdx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             confirm
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SLL   = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             confirm_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             is_multi;
  logic             is_mul_in;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_d;
  logic [WIDTH-1:0] hi_d, lo_d, fin_d;

  // Handshake: DONE can take a new op in the same cycle its result is consumed.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign confirm   = confirm_q;
  assign accept    = in_valid && in_ready;

  assign is_mul_in = (alu_decode == OP_MUL) || (alu_decode == OP_MULHU);
  assign is_multi  = ENABLE_MULDIV &&
                     (is_mul_in || (alu_decode == OP_DIVU) || (alu_decode == OP_REMU));
  assign shamt     = rdx[SW-1:0];

  // Single-cycle datapath; undefined (and disabled mul/div) ops yield zero.
  always_comb begin
    alu_d = '0;
    case (alu_decode)
      OP_AND:  alu_d = rda & rdx;
      OP_OR:   alu_d = rda | rdx;
      OP_ADD:  alu_d = rda + rdx;
      OP_SLL:  alu_d = rda << shamt;
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(rda) < $signed(rdx))};
      OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, (rda < rdx)};
      OP_SUB:  alu_d = rda - rdx;
      OP_XOR:  alu_d = rda ^ rdx;
      OP_SRL:  alu_d = rda >> shamt;
      OP_SRA:  alu_d = WIDTH'($signed(rda) >>> shamt);
      default: alu_d = '0;
    endcase
  end

  // One iteration step. Multiply: shift-add with the multiplier in lo, the
  // multiplicand in b. Divide: restoring step with the dividend shifting out
  // of lo into the remainder in hi; a zero divisor naturally gives
  // quotient=all ones, remainder=dividend.
  always_comb begin
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rs;
    logic [WIDTH-1:0] diff;
    logic             ge;
    sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    rs   = {hi_q, lo_q[WIDTH-1]};
    ge   = (rs >= {1'b0, b_q});
    diff = rs[WIDTH-1:0] - b_q;
    hi_d = '0;
    lo_d = '0;
    if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_d = ge ? diff : rs[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge};
    end
    fin_d = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? lo_q : hi_q;
  end

  // Control FSM plus registered result/confirm.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      confirm_q <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      if (is_multi) begin
        op_q    <= alu_decode;
        hi_q    <= '0;
        lo_q    <= is_mul_in ? rdx : rda;
        b_q     <= is_mul_in ? rda : rdx;
        cnt_q   <= CW'(WIDTH);
        state_q <= BUSY;
      end else begin
        result_q  <= alu_d;
        confirm_q <= (alu_d == '0);
        state_q   <= DONE;
      end
    end else begin
      case (state_q)
        BUSY: begin
          if (cnt_q == '0) begin
            result_q  <= fin_d;
            confirm_q <= (fin_d == '0);
            state_q   <= DONE;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    if (out_ready) state_q <= IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 32-bit instance for most scenarios, 16-bit
// instance for the reduced-width back-to-back rerun.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, confirm;
  logic [3:0]  alu_decode;
  logic [31:0] rda, rdx, result;

  logic        v16, ir16, ov16, or16, cf16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, res16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_decode(alu_decode), .rda(rda), .rdx(rdx), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .confirm(confirm));

  alu_seq #(.WIDTH(16), .ENABLE_MULDIV(1'b1)) dut16 (
    .clk(clk), .reset(reset), .in_valid(v16), .in_ready(ir16),
    .alu_decode(op16), .rda(a16), .rdx(b16), .out_valid(ov16),
    .out_ready(or16), .result(res16), .confirm(cf16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op for one clock, then drop in_valid.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; alu_decode = op; rda = a; rdx = b;
    tick;
    in_valid = 1'b0;
  endtask

  // Count cycles until out_valid (bounded); note whether in_ready was seen high.
  task automatic wait_valid(output int n, output bit saw_ready);
    n = 0; saw_ready = 1'b0;
    while (!out_valid && n < 200) begin
      if (in_ready) saw_ready = 1'b1;
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    int hits;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_decode = '0; rda = '0; rdx = '0;
    v16 = 1'b0; or16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    tick; tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (confirm !== 1'b0) begin errors++; $display("FAIL reset_confirm got=%b exp=0", confirm); end
    reset = 1'b0;
    // Reset in the middle of a divide.
    drive(4'd12, 32'd100, 32'd7);
    repeat (5) tick;
    reset = 1'b1; tick; tick; reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL middiv_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL middiv_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL middiv_result got=%h exp=0", result); end
    out_ready = 1'b1;
    hits = 0;
    repeat (40) begin tick; if (out_valid) hits++; end
    checks++; if (hits !== 0) begin errors++; $display("FAIL middiv_stale got=%0d exp=0 valid cycles", hits); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    in_valid = 1'b1; alu_decode = 4'd2; rda = 32'hFFFF_FFFF; rdx = 32'h1;
    tick;
    checks++; if (out_valid !== 1'b1 || result !== 32'h0 || confirm !== 1'b1)
      begin errors++; $display("FAIL b2b_add got v=%b r=%h c=%b exp v=1 r=0 c=1", out_valid, result, confirm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    alu_decode = 4'd7; rda = 32'h5A5A_5A5A; rdx = 32'h5A5A_5A5A;
    tick;
    checks++; if (out_valid !== 1'b1 || result !== 32'h0 || confirm !== 1'b1)
      begin errors++; $display("FAIL b2b_xor got v=%b r=%h c=%b exp v=1 r=0 c=1", out_valid, result, confirm); end
    alu_decode = 4'd1; rda = 32'h0000_00F0; rdx = 32'h0000_000F;
    tick;
    checks++; if (result !== 32'h0000_00FF || confirm !== 1'b0)
      begin errors++; $display("FAIL b2b_or got r=%h c=%b exp r=000000ff c=0", result, confirm); end
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0 || result !== 32'h0000_00FF)
      begin errors++; $display("FAIL b2b_drop got v=%b r=%h exp v=0 r=000000ff", out_valid, result); end
  endtask

  task automatic test_shift_cmp;
    out_ready = 1'b1;
    drive(4'd9, 32'h8000_0000, 32'h24);
    checks++; if (result !== 32'hF800_0000) begin errors++; $display("FAIL sra got=%h exp=f8000000", result); end
    drive(4'd4, 32'hFFFF_FFFF, 32'h1);
    checks++; if (result !== 32'h1 || confirm !== 1'b0) begin errors++; $display("FAIL slt got=%h c=%b exp=1 c=0", result, confirm); end
    drive(4'd5, 32'hFFFF_FFFF, 32'h1);
    checks++; if (result !== 32'h0 || confirm !== 1'b1) begin errors++; $display("FAIL sltu got=%h c=%b exp=0 c=1", result, confirm); end
    drive(4'd3, 32'h0000_0003, 32'h21);
    checks++; if (result !== 32'h6) begin errors++; $display("FAIL sll got=%h exp=6", result); end
    drive(4'd8, 32'h8000_0000, 32'h1F);
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL srl got=%h exp=1", result); end
    drive(4'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
    checks++; if (result !== 32'h00F0_1200) begin errors++; $display("FAIL and got=%h exp=00f01200", result); end
    tick;
  endtask

  task automatic test_undef;
    out_ready = 1'b1;
    drive(4'd1, 32'h1, 32'h2);
    checks++; if (result !== 32'h3) begin errors++; $display("FAIL pre_undef got=%h exp=3", result); end
    drive(4'd14, 32'h1234, 32'h5678);
    checks++; if (out_valid !== 1'b1 || result !== 32'h0 || confirm !== 1'b1)
      begin errors++; $display("FAIL undef14 got v=%b r=%h c=%b exp v=1 r=0 c=1", out_valid, result, confirm); end
    tick;
  endtask

  task automatic test_mul;
    int n; bit sr;
    out_ready = 1'b1;
    drive(4'd10, 32'h0001_0000, 32'h0001_0000);
    wait_valid(n, sr);
    checks++; if (n !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", n); end
    checks++; if (result !== 32'h0 || confirm !== 1'b1) begin errors++; $display("FAIL mul got=%h c=%b exp=0 c=1", result, confirm); end
    tick;
    drive(4'd11, 32'h0001_0000, 32'h0001_0000);
    wait_valid(n, sr);
    checks++; if (result !== 32'h1 || confirm !== 1'b0) begin errors++; $display("FAIL mulhu got=%h c=%b exp=1 c=0", result, confirm); end
    tick;
    drive(4'd10, 32'h1234_5678, 32'h0000_0010);
    wait_valid(n, sr);
    checks++; if (result !== 32'h2345_6780) begin errors++; $display("FAIL mul2 got=%h exp=23456780", result); end
    tick;
  endtask

  task automatic test_div;
    int n; bit sr;
    out_ready = 1'b1;
    drive(4'd12, 32'd100, 32'd7);
    wait_valid(n, sr);
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL divu got=%0d exp=14", result); end
    checks++; if (sr !== 1'b0) begin errors++; $display("FAIL divu_busy_ready got=%b exp=0", sr); end
    tick;
    drive(4'd13, 32'd100, 32'd7);
    wait_valid(n, sr);
    checks++; if (result !== 32'd2) begin errors++; $display("FAIL remu got=%0d exp=2", result); end
    tick;
    drive(4'd12, 32'd5, 32'd0);
    wait_valid(n, sr);
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0 got=%h exp=ffffffff", result); end
    tick;
    drive(4'd13, 32'd5, 32'd0);
    wait_valid(n, sr);
    checks++; if (result !== 32'd5 || sr !== 1'b0) begin errors++; $display("FAIL remu0 got=%h ready_seen=%b exp=5 ready_seen=0", result, sr); end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(4'd6, 32'd3, 32'd5);
    checks++; if (result !== 32'hFFFF_FFFE || out_valid !== 1'b1) begin errors++; $display("FAIL sub got=%h v=%b exp=fffffffe v=1", result, out_valid); end
    in_valid = 1'b1; alu_decode = 4'd2; rda = 32'd1; rdx = 32'd1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      tick;
      checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE)
        begin errors++; $display("FAIL bp_hold cyc=%0d got v=%b r=%h exp v=1 r=fffffffe", i, out_valid, result); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd2) begin errors++; $display("FAIL bp_next got v=%b r=%h exp v=1 r=2", out_valid, result); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_w16;
    int n;
    or16 = 1'b1;
    v16 = 1'b1; op16 = 4'd2; a16 = 16'hFFFF; b16 = 16'h0001;
    tick;
    checks++; if (ov16 !== 1'b1 || res16 !== 16'h0 || cf16 !== 1'b1)
      begin errors++; $display("FAIL w16_add got v=%b r=%h c=%b exp v=1 r=0 c=1", ov16, res16, cf16); end
    op16 = 4'd7; a16 = 16'h5A5A; b16 = 16'h5A5A;
    tick;
    checks++; if (ov16 !== 1'b1 || res16 !== 16'h0 || cf16 !== 1'b1)
      begin errors++; $display("FAIL w16_xor got v=%b r=%h c=%b exp v=1 r=0 c=1", ov16, res16, cf16); end
    op16 = 4'd11; a16 = 16'h0100; b16 = 16'h0300;
    tick;
    v16 = 1'b0;
    n = 0;
    while (!ov16 && n < 100) begin tick; n++; end
    checks++; if (n !== 17 || res16 !== 16'h0003)
      begin errors++; $display("FAIL w16_mulhu got lat=%0d r=%h exp lat=17 r=0003", n, res16); end
    tick;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_shift_cmp;
    test_undef;
    test_mul;
    test_div;
    test_backpressure;
    test_w16;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
